// File: rtl/sccb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sccb_pkg
//  Description : Shared definitions for the SCCB target. Holds the protocol
//                state encoding, ACK/NACK bus levels, the default device,
//                chip-ID address and chip-ID values, and a helper that flags
//                the two read-only ID register addresses.
//  Revision    : 1.0 - initial release
// ============================================================================
package sccb_pkg;

    // Protocol phases. Each state covers the SCL bit periods of one field.
    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_DEV_ADDR = 4'd1,
        ST_DEV_ACK  = 4'd2,
        ST_REG_HI   = 4'd3,
        ST_ACK_HI   = 4'd4,
        ST_REG_LO   = 4'd5,
        ST_ACK_LO   = 4'd6,
        ST_WR_DATA  = 4'd7,
        ST_WR_ACK   = 4'd8,
        ST_RD_DATA  = 4'd9,
        ST_RD_ACK   = 4'd10
    } sccb_state_t;

    // SDA level meaning ACK / NACK. NACK is also the "released" level.
    localparam logic C_ACK  = 1'b0;
    localparam logic C_NACK = 1'b1;

    localparam logic [6:0]  C_DEF_DEV_ADDR     = 7'h3C;
    localparam logic [15:0] C_DEF_CHIP_ID_ADDR = 16'h300A;
    localparam logic [15:0] C_DEF_CHIP_ID      = 16'h5640;

    // True for either byte of the hardwired chip-ID pair.
    function automatic logic is_id_addr(input logic [15:0] addr,
                                        input logic [15:0] base);
        return (addr == base) || (addr == (base + 16'd1));
    endfunction

endpackage : sccb_pkg
`default_nettype wire

// File: rtl/sccb_in_filter.sv
`default_nettype none
// ============================================================================
//  Module      : sccb_in_filter
//  Description : Pad conditioning for one SCCB line: a 2-flop synchronizer
//                followed by a glitch filter that only moves its level after
//                FILT_LEN consecutive identical synchronized samples. Emits
//                the filtered level and single-clock rise/fall pulses.
//  Ports       : clk_50m  - clock
//                rst_n    - synchronous active-low reset (level resets high)
//                i_pin    - raw pad input
//                o_level  - filtered level
//                o_rise   - one-clock pulse on filtered 0->1
//                o_fall   - one-clock pulse on filtered 1->0
//  Revision    : 1.0 - initial release
// ============================================================================
module sccb_in_filter #(
    parameter int FILT_LEN = 3
) (
    input  logic clk_50m,
    input  logic rst_n,
    input  logic i_pin,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    localparam int            CW     = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
    localparam logic [CW-1:0] C_LAST = CW'(FILT_LEN - 1);

    logic [1:0]    r_sync;
    logic [CW-1:0] r_cnt;
    logic          r_level;
    logic          r_level_d;

    always_ff @(posedge clk_50m) begin
        if (!rst_n) begin
            // Idle bus is high; resetting high avoids a false edge at release.
            r_sync    <= 2'b11;
            r_cnt     <= '0;
            r_level   <= 1'b1;
            r_level_d <= 1'b1;
        end else begin
            r_sync    <= {r_sync[0], i_pin};
            r_level_d <= r_level;
            if (r_sync[1] == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == C_LAST) begin
                r_level <= r_sync[1];
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign o_level = r_level;
    assign o_rise  = r_level & ~r_level_d;
    assign o_fall  = ~r_level & r_level_d;

endmodule : sccb_in_filter
`default_nettype wire

// File: rtl/sccb_target.sv
`default_nettype none
// ============================================================================
//  Module      : sccb_target
//  Description : SCCB/I2C responder emulating a camera register interface:
//                7-bit device address, 16-bit register pointer, 8-bit data.
//                Small register file plus a read-only chip-ID pair. Never
//                stretches SCL; SDA is driven open-drain via sda_t.
//  Ports       : clk_50m, rst_n (sync, active-low)
//                scl_i/scl_o/scl_t, sda_i/sda_o/sda_t  - pad triplets
//                busy                                  - addressed until STOP
//                reg_wr_valid/addr/data                - write strobe
//  Build macro : SCCB_TGT_WR_PORT_EN - adds the reg_wr_* write strobe ports.
//  Revision    : 1.0 - initial release
// ============================================================================
module sccb_target
    import sccb_pkg::*;
#(
    parameter logic [6:0]  DEV_ADDR     = C_DEF_DEV_ADDR,
    parameter int          ADDR_BITS    = 8,
    parameter logic [15:0] CHIP_ID_ADDR = C_DEF_CHIP_ID_ADDR,
    parameter logic [15:0] CHIP_ID      = C_DEF_CHIP_ID,
    parameter int          FILT_LEN     = 3,
    parameter int          HOLD_CYC     = 10
) (
    input  logic        clk_50m,
    input  logic        rst_n,
    input  logic        scl_i,
    output logic        scl_o,
    output logic        scl_t,
    input  logic        sda_i,
    output logic        sda_o,
    output logic        sda_t,
    output logic        busy
`ifdef SCCB_TGT_WR_PORT_EN
   ,output logic        reg_wr_valid,
    output logic [15:0] reg_wr_addr,
    output logic [7:0]  reg_wr_data
`endif
);

    localparam int            DEPTH       = 1 << ADDR_BITS;
    localparam int            HW          = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
    localparam logic [HW-1:0] C_HOLD_LOAD = HW'(HOLD_CYC - 1);

    // Conditioned bus
    logic w_scl_lvl, w_scl_rise, w_scl_fall;
    logic w_sda_lvl, w_sda_rise, w_sda_fall;
    logic w_start, w_stop;

    sccb_state_t r_state, w_state_nxt;

    logic [3:0]    r_bit_cnt;
    logic [7:0]    r_shift;
    logic          r_mack;
    logic [15:0]   r_ptr;
    logic [7:0]    r_mem [DEPTH];
    logic          r_wr_pend;
    logic          r_busy;

    logic          r_sda_t;
    logic          r_hold_act;
    logic          r_hold_val;
    logic [HW-1:0] r_hold_cnt;

    logic          w_byte_end;
    logic          w_rx_state;
    logic          w_drive_req;
    logic          w_drive_val;
    logic          w_load_rd;
    logic [15:0]   w_rd_addr;
    logic [7:0]    w_rd_byte;
    logic          w_wr_commit;

    sccb_in_filter #(.FILT_LEN(FILT_LEN)) u_scl_filt (
        .clk_50m (clk_50m),
        .rst_n   (rst_n),
        .i_pin   (scl_i),
        .o_level (w_scl_lvl),
        .o_rise  (w_scl_rise),
        .o_fall  (w_scl_fall)
    );

    sccb_in_filter #(.FILT_LEN(FILT_LEN)) u_sda_filt (
        .clk_50m (clk_50m),
        .rst_n   (rst_n),
        .i_pin   (sda_i),
        .o_level (w_sda_lvl),
        .o_rise  (w_sda_rise),
        .o_fall  (w_sda_fall)
    );

    assign w_start    = w_sda_fall & w_scl_lvl;
    assign w_stop     = w_sda_rise & w_scl_lvl;
    assign w_byte_end = w_scl_fall && (r_bit_cnt == 4'd8);
    assign w_rx_state = (r_state == ST_DEV_ADDR) || (r_state == ST_REG_HI) ||
                        (r_state == ST_REG_LO)   || (r_state == ST_WR_DATA);

    // Next read byte: the current pointer when entering from the address ACK,
    // the following one when the initiator ACKed the previous byte.
    assign w_rd_addr = (r_state == ST_RD_ACK) ? (r_ptr + 16'd1) : r_ptr;

    always_comb begin
        w_rd_byte = r_mem[w_rd_addr[ADDR_BITS-1:0]];
        if (w_rd_addr == CHIP_ID_ADDR) begin
            w_rd_byte = CHIP_ID[15:8];
        end else if (w_rd_addr == (CHIP_ID_ADDR + 16'd1)) begin
            w_rd_byte = CHIP_ID[7:0];
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_50m) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and SDA drive requests. Bit boundaries are SCL falls;
    // every drive request is applied HOLD_CYC clocks later, inside SCL low.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_drive_req = 1'b0;
        w_drive_val = C_NACK;
        w_load_rd   = 1'b0;
        if (w_start) begin
            w_state_nxt = ST_DEV_ADDR;
        end else if (w_stop) begin
            w_state_nxt = ST_IDLE;
        end else if (w_scl_fall) begin
            case (r_state)
                ST_DEV_ADDR: begin
                    if (w_byte_end) begin
                        if (r_shift[7:1] == DEV_ADDR) begin
                            w_state_nxt = ST_DEV_ACK;
                            w_drive_req = 1'b1;
                            w_drive_val = C_ACK;
                        end else begin
                            w_state_nxt = ST_IDLE;
                        end
                    end
                end
                ST_DEV_ACK: begin
                    // r_shift still holds the address byte; bit 0 is R/W.
                    w_drive_req = 1'b1;
                    if (r_shift[0]) begin
                        w_state_nxt = ST_RD_DATA;
                        w_load_rd   = 1'b1;
                        w_drive_val = w_rd_byte[7];
                    end else begin
                        w_state_nxt = ST_REG_HI;
                    end
                end
                ST_REG_HI: begin
                    if (w_byte_end) begin
                        w_state_nxt = ST_ACK_HI;
                        w_drive_req = 1'b1;
                        w_drive_val = C_ACK;
                    end
                end
                ST_ACK_HI: begin
                    w_state_nxt = ST_REG_LO;
                    w_drive_req = 1'b1;
                end
                ST_REG_LO: begin
                    if (w_byte_end) begin
                        w_state_nxt = ST_ACK_LO;
                        w_drive_req = 1'b1;
                        w_drive_val = C_ACK;
                    end
                end
                ST_ACK_LO: begin
                    w_state_nxt = ST_WR_DATA;
                    w_drive_req = 1'b1;
                end
                ST_WR_DATA: begin
                    if (w_byte_end) begin
                        w_state_nxt = ST_WR_ACK;
                        w_drive_req = 1'b1;
                        w_drive_val = C_ACK;
                    end
                end
                ST_WR_ACK: begin
                    w_state_nxt = ST_WR_DATA;
                    w_drive_req = 1'b1;
                end
                ST_RD_DATA: begin
                    w_drive_req = 1'b1;
                    if (w_byte_end) begin
                        w_state_nxt = ST_RD_ACK;
                    end else begin
                        w_drive_val = r_shift[6];
                    end
                end
                ST_RD_ACK: begin
                    if (r_mack) begin
                        w_state_nxt = ST_RD_DATA;
                        w_load_rd   = 1'b1;
                        w_drive_req = 1'b1;
                        w_drive_val = w_rd_byte[7];
                    end else begin
                        // SDA is already released for the initiator's NACK.
                        w_state_nxt = ST_IDLE;
                    end
                end
                default: begin
                    w_state_nxt = r_state;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Datapath: bit counter, shift register, pointer, busy
    // ------------------------------------------------------------------
    assign w_wr_commit = r_wr_pend && !is_id_addr(r_ptr, CHIP_ID_ADDR);

    always_ff @(posedge clk_50m) begin
        if (!rst_n) begin
            r_bit_cnt <= 4'd0;
            r_shift   <= 8'd0;
            r_mack    <= 1'b0;
            r_ptr     <= 16'd0;
            r_wr_pend <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            if (w_start || (w_state_nxt != r_state)) begin
                r_bit_cnt <= 4'd0;
            end else if (w_scl_rise && (w_rx_state || (r_state == ST_RD_DATA)) &&
                         (r_bit_cnt != 4'd8)) begin
                r_bit_cnt <= r_bit_cnt + 4'd1;
            end

            if (w_load_rd) begin
                r_shift <= w_rd_byte;
            end else if ((r_state == ST_RD_DATA) && w_scl_fall) begin
                r_shift <= {r_shift[6:0], 1'b0};
            end else if (w_scl_rise && w_rx_state && (r_bit_cnt != 4'd8)) begin
                r_shift <= {r_shift[6:0], w_sda_lvl};
            end

            if (w_scl_rise && (r_state == ST_RD_ACK)) begin
                r_mack <= (w_sda_lvl == C_ACK);
            end

            // Commit happens the clock after the 8th data bit lands in r_shift.
            r_wr_pend <= w_scl_rise && (r_state == ST_WR_DATA) &&
                         (r_bit_cnt == 4'd7) && !w_start && !w_stop;

            if (r_wr_pend) begin
                r_ptr <= r_ptr + 16'd1;
            end else if ((r_state == ST_REG_HI) && (w_state_nxt == ST_ACK_HI)) begin
                r_ptr[15:8] <= r_shift;
            end else if ((r_state == ST_REG_LO) && (w_state_nxt == ST_ACK_LO)) begin
                r_ptr[7:0] <= r_shift;
            end else if ((r_state == ST_RD_ACK) && (w_state_nxt == ST_RD_DATA)) begin
                r_ptr <= r_ptr + 16'd1;
            end

            if (w_stop) begin
                r_busy <= 1'b0;
            end else if ((r_state == ST_DEV_ADDR) && (w_state_nxt == ST_DEV_ACK)) begin
                r_busy <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_50m) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= 8'd0;
            end
        end else if (w_wr_commit) begin
            r_mem[r_ptr[ADDR_BITS-1:0]] <= r_shift;
        end
    end

    // ------------------------------------------------------------------
    // SDA driver with hold delay. START/STOP release at once so the target
    // never fights the initiator while it owns the line.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_50m) begin
        if (!rst_n) begin
            r_sda_t    <= 1'b1;
            r_hold_act <= 1'b0;
            r_hold_val <= 1'b1;
            r_hold_cnt <= '0;
        end else if (w_start || w_stop) begin
            r_sda_t    <= 1'b1;
            r_hold_act <= 1'b0;
        end else if (w_drive_req) begin
            r_hold_act <= 1'b1;
            r_hold_val <= w_drive_val;
            r_hold_cnt <= C_HOLD_LOAD;
        end else if (r_hold_act) begin
            if (r_hold_cnt == '0) begin
                r_sda_t    <= r_hold_val;
                r_hold_act <= 1'b0;
            end else begin
                r_hold_cnt <= r_hold_cnt - HW'(1);
            end
        end
    end

`ifdef SCCB_TGT_WR_PORT_EN
    always_ff @(posedge clk_50m) begin
        if (!rst_n) begin
            reg_wr_valid <= 1'b0;
            reg_wr_addr  <= 16'd0;
            reg_wr_data  <= 8'd0;
        end else begin
            reg_wr_valid <= w_wr_commit;
            if (w_wr_commit) begin
                reg_wr_addr <= r_ptr;
                reg_wr_data <= r_shift;
            end
        end
    end
`endif

    assign scl_o = 1'b0;
    assign scl_t = 1'b1;
    assign sda_o = 1'b0;
    assign sda_t = r_sda_t;
    assign busy  = r_busy;

endmodule : sccb_target
`default_nettype wire

// File: tb/tb_sccb_target.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sccb_target
//  Description : Self-checking bench for sccb_target. Acts as bus initiator
//                over an open-drain bus model and compares every ACK, read
//                byte and status output against a register-file model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sccb_target;

    logic clk_50m = 1'b0;
    logic rst_n   = 1'b0;
    logic scl_m   = 1'b1;
    logic sda_m   = 1'b1;
    logic scl_i, sda_i, scl_o, scl_t, sda_o, sda_t, busy;
`ifdef SCCB_TGT_WR_PORT_EN
    logic        reg_wr_valid;
    logic [15:0] reg_wr_addr;
    logic [7:0]  reg_wr_data;
    logic [23:0] q_strobe [$];
`endif

    int          n_asrt = 0;
    int          n_fail = 0;
    logic [7:0]  m_mem [256];
    logic [15:0] m_ptr;

    always #10 clk_50m = ~clk_50m;

    // Wired-AND bus: line is low if the initiator or the target pulls it.
    assign scl_i = scl_m & (scl_t | scl_o);
    assign sda_i = sda_m & (sda_t | sda_o);

    sccb_target dut (
        .clk_50m      (clk_50m),
        .rst_n        (rst_n),
        .scl_i        (scl_i),
        .scl_o        (scl_o),
        .scl_t        (scl_t),
        .sda_i        (sda_i),
        .sda_o        (sda_o),
        .sda_t        (sda_t),
        .busy         (busy)
`ifdef SCCB_TGT_WR_PORT_EN
       ,.reg_wr_valid (reg_wr_valid),
        .reg_wr_addr  (reg_wr_addr),
        .reg_wr_data  (reg_wr_data)
`endif
    );

`ifdef SCCB_TGT_WR_PORT_EN
    always @(negedge clk_50m) begin
        if (reg_wr_valid) q_strobe.push_back({reg_wr_addr, reg_wr_data});
    end
`endif

    initial begin
        #1_900_000;
        $display("FAIL watchdog: observed no end of test, expected finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- model ----------------
    function automatic logic is_id(input logic [15:0] a);
        return (a == 16'h300A) || (a == 16'h300B);
    endfunction

    function automatic logic [7:0] m_rd(input logic [15:0] a);
        if (a == 16'h300A) return 8'h56;
        if (a == 16'h300B) return 8'h40;
        return m_mem[a[7:0]];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 256; i++) m_mem[i] = 8'h00;
        m_ptr = 16'h0000;
    endtask

    // ---------------- helpers ----------------
    task automatic wc(input int n);
        repeat (n) @(negedge clk_50m);
    endtask

    task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic i2c_start();
        wc(22); sda_m = 1'b1; wc(8); scl_m = 1'b1;
        wc(30); sda_m = 1'b0; wc(30); scl_m = 1'b0;
    endtask

    task automatic i2c_stop();
        wc(22); sda_m = 1'b0; wc(8); scl_m = 1'b1;
        wc(30); sda_m = 1'b1; wc(30);
        chk("busy_after_stop", 24'(busy), 24'd0);
    endtask

    task automatic wbyte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) begin
            wc(22); sda_m = b[i]; wc(8); scl_m = 1'b1; wc(30); scl_m = 1'b0;
        end
        wc(22); sda_m = 1'b1; wc(8); scl_m = 1'b1; wc(15);
        ack = ~sda_i;
        wc(15); scl_m = 1'b0;
    endtask

    task automatic rbyte(input logic mack, output logic [7:0] d);
        for (int i = 7; i >= 0; i--) begin
            wc(22); sda_m = 1'b1; wc(8); scl_m = 1'b1; wc(15);
            d[i] = sda_i;
            wc(15); scl_m = 1'b0;
        end
        wc(22); sda_m = ~mack; wc(8); scl_m = 1'b1; wc(30); scl_m = 1'b0;
    endtask

    task automatic set_ptr(input logic [15:0] p, input logic do_stop);
        logic ack;
        i2c_start();
        wbyte(8'h78, ack);  chk("dev_wr_ack", 24'(ack), 24'd1);
        chk("busy_addressed", 24'(busy), 24'd1);
        wbyte(p[15:8], ack); chk("ptr_hi_ack", 24'(ack), 24'd1);
        wbyte(p[7:0], ack);  chk("ptr_lo_ack", 24'(ack), 24'd1);
        m_ptr = p;
        if (do_stop) i2c_stop();
    endtask

    task automatic wr_data(input logic [7:0] d);
        logic ack;
        wbyte(d, ack);
        chk("wr_data_ack", 24'(ack), 24'd1);
`ifdef SCCB_TGT_WR_PORT_EN
        if (is_id(m_ptr)) begin
            chk("id_no_strobe", 24'(q_strobe.size()), 24'd0);
        end else begin
            chk("strobe_count", 24'(q_strobe.size()), 24'd1);
            if (q_strobe.size() > 0) chk("strobe_addr_data", q_strobe[0], {m_ptr, d});
        end
        q_strobe.delete();
`endif
        if (!is_id(m_ptr)) m_mem[m_ptr[7:0]] = d;
        m_ptr = m_ptr + 16'd1;
    endtask

    // Sr + read n bytes (ACK all but the last), then STOP.
    task automatic rd_seq(input int n);
        logic       ack;
        logic [7:0] d;
        i2c_start();
        wbyte(8'h79, ack); chk("dev_rd_ack", 24'(ack), 24'd1);
        for (int i = 0; i < n; i++) begin
            rbyte(i != n - 1, d);
            chk("rd_data", 24'(d), 24'(m_rd(m_ptr)));
            if (i != n - 1) m_ptr = m_ptr + 16'd1;
        end
        wc(20);
        chk("sda_released_after_nack", 24'(sda_t), 24'd1);
        i2c_stop();
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        logic        ack;
        logic [15:0] p;
        model_reset();

        wc(6);
        chk("rst_sda_t", 24'(sda_t), 24'd1);
        chk("rst_sda_o", 24'(sda_o), 24'd0);
        chk("rst_scl_t", 24'(scl_t), 24'd1);
        chk("rst_scl_o", 24'(scl_o), 24'd0);
        chk("rst_busy",  24'(busy),  24'd0);
`ifdef SCCB_TGT_WR_PORT_EN
        chk("rst_wr_valid", 24'(reg_wr_valid), 24'd0);
`endif
        rst_n = 1'b1;
        wc(20);

        // Write 0xA5, 0x5A at 0x3008.
        set_ptr(16'h3008, 1'b0);
        wr_data(8'hA5);
        wr_data(8'h5A);
        i2c_stop();

        // Pointer write, Sr, read two.
        set_ptr(16'h3008, 1'b0);
        rd_seq(2);

        // Chip-ID reads and discarded ID write.
        set_ptr(16'h300A, 1'b0);
        rd_seq(2);
        set_ptr(16'h300A, 1'b0);
        wr_data(8'h11);
        i2c_stop();
        set_ptr(16'h300A, 1'b0);
        rd_seq(1);

        // Foreign address: no ACK, not busy, file untouched.
        i2c_start();
        wbyte(8'h84, ack); chk("foreign_addr_nack", 24'(ack), 24'd0);
        chk("foreign_not_busy", 24'(busy), 24'd0);
        wbyte(8'h30, ack); chk("foreign_ptr_hi_nack", 24'(ack), 24'd0);
        wbyte(8'h08, ack); chk("foreign_ptr_lo_nack", 24'(ack), 24'd0);
        wbyte(8'hFF, ack); chk("foreign_data_nack", 24'(ack), 24'd0);
        i2c_stop();
        set_ptr(16'h3008, 1'b0);
        rd_seq(1);

        // Pointer wrap 0xFFFF -> 0x0000.
        set_ptr(16'hFFFF, 1'b0);
        wr_data(8'h01);
        wr_data(8'h02);
        i2c_stop();
        chk("model_ptr_wrapped", 24'(m_ptr), 24'h000001);
        set_ptr(16'hFFFF, 1'b0);
        rd_seq(2);

        // Reset mid read byte (first bit of 0x5A is 0, so SDA is pulled).
        set_ptr(16'h3009, 1'b0);
        i2c_start();
        wbyte(8'h79, ack); chk("pre_rst_rd_ack", 24'(ack), 24'd1);
        wc(22);
        chk("rd_msb_driven", 24'(sda_t), 24'd0);
        @(negedge clk_50m); rst_n = 1'b0;
        @(posedge clk_50m); #1;
        chk("rst_mid_release", 24'(sda_t), 24'd1);
        chk("rst_mid_busy", 24'(busy), 24'd0);
        wc(3); rst_n = 1'b1;
        model_reset();
        i2c_stop();
        set_ptr(16'h3009, 1'b0);
        rd_seq(1);
        set_ptr(16'h0040, 1'b0);
        wr_data(8'h3C);
        i2c_stop();
        set_ptr(16'h0040, 1'b0);
        rd_seq(1);

        // Randomized write/readback.
        for (int r = 0; r < 3; r++) begin
            p = 16'($urandom);
            set_ptr(p, 1'b0);
            wr_data(8'($urandom));
            wr_data(8'($urandom));
            i2c_stop();
            set_ptr(p, 1'b0);
            rd_seq(2);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule : tb_sccb_target
`default_nettype wire
